labs_best_tracker: RTL

//  Receiving end of the calc_e result stream (seq, energy, valid) in the LABS search datapath.

---
 rtl/labs_pkg.sv | 17 +
 rtl/labs_result_fifo.sv | 64 ++++++
 rtl/labs_best_tracker.sv | 96 +++++++++
 3 files changed

// File: rtl/labs_pkg.sv
// rtl/labs_pkg.sv - shared widths and report entry layout for the LABS best tracker
package labs_pkg;

    localparam int LABS_SEQ_W = 8;
    localparam int LABS_E_W   = 20;
    localparam int LABS_CNT_W = 32;
    localparam int LABS_DEPTH = 4;

    // Report entry is packed {seq, e, idx} with idx in the low bits.
    localparam int ENTRY_W = LABS_SEQ_W + LABS_E_W + LABS_CNT_W;
    localparam int IDX_LSB = 0;
    localparam int E_LSB   = IDX_LSB + LABS_CNT_W;
    localparam int SEQ_LSB = E_LSB + LABS_E_W;

    localparam logic [LABS_E_W-1:0] E_MAX = {LABS_E_W{1'b1}};

endpackage

// File: rtl/labs_result_fifo.sv
// rtl/labs_result_fifo.sv - generic first-word-fall-through sync FIFO with level
module labs_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/labs_best_tracker.sv
// rtl/labs_best_tracker.sv - tracks lowest-energy LABS candidate and reports improvements
module labs_best_tracker
    import labs_pkg::*;
#(
    parameter int SEQ_WIDTH  = LABS_SEQ_W,
    parameter int E_WIDTH    = LABS_E_W,
    parameter int FIFO_DEPTH = LABS_DEPTH,
    parameter int CNT_WIDTH  = LABS_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEQ_WIDTH-1:0]          i_seq,
    input  logic [E_WIDTH-1:0]            i_e,
    input  logic                          i_valid,
    input  logic                          i_clear,
    output logic [SEQ_WIDTH-1:0]          best_seq,
    output logic [E_WIDTH-1:0]            best_e,
    output logic                          best_valid,
    output logic [CNT_WIDTH-1:0]          o_count,
    output logic [SEQ_WIDTH-1:0]          o_seq,
    output logic [E_WIDTH-1:0]            o_e,
    output logic [CNT_WIDTH-1:0]          o_idx,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
);

    localparam int EW     = SEQ_WIDTH + E_WIDTH + CNT_WIDTH;
    localparam int E_OFF  = IDX_LSB + CNT_WIDTH;
    localparam int S_OFF  = E_OFF + E_WIDTH;

    logic           accept;
    logic           new_best;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [EW-1:0]  push_entry;
    logic [EW-1:0]  head;

    assign accept     = i_valid & ~i_clear;
    assign new_best   = accept & (~best_valid | (i_e < best_e));
    assign pop        = i_ready & ~fifo_empty;
    assign push_entry = {i_seq, i_e, o_count};

    labs_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_clear),
        .push  (new_best),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_seq   <= '0;
            best_e     <= '0;
            best_valid <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            best_seq   <= '0;
            best_e     <= '0;
            best_valid <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (new_best) begin
                best_seq   <= i_seq;
                best_e     <= i_e;
                best_valid <= 1'b1;
            end
            if (accept && (o_count != '1)) begin
                o_count <= o_count + 1'b1;
            end
            if (new_best && fifo_full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Head fields read as zero while empty so reset/clear leaves every output at 0.
    assign o_valid = ~fifo_empty;
    assign o_seq   = o_valid ? head[S_OFF +: SEQ_WIDTH] : '0;
    assign o_e     = o_valid ? head[E_OFF +: E_WIDTH]   : '0;
    assign o_idx   = o_valid ? head[IDX_LSB +: CNT_WIDTH] : '0;

endmodule
